// File: rtl/stub_player_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stub_player_pkg
// Brief    : Shared types and widths for the event-framed stub player.
// Revision : 1.0 - initial release
// ============================================================================
package stub_player_pkg;

    localparam int c_stub_w    = 36;
    localparam int c_trunc_w   = 16;
    localparam int c_realign_w = 8;

    // FIFO entry layout at the default stub width: marker above payload.
    typedef struct packed {
        logic                marker;
        logic [c_stub_w-1:0] data;
    } stub_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } player_state_t;

endpackage
`default_nettype wire

// File: rtl/stub_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stub_fifo
// Brief    : Synchronous FIFO of {marker, data} entries with registered read
//            data and a combinational peek of the head's marker bit.
// Revision : 1.0 - initial release
// ============================================================================
module stub_fifo #(
    parameter int DATA_W = 36,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_marker,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              head_marker,
    output logic              full,
    output logic              empty
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_depth = (c_addr_w + 1)'(DEPTH);

    logic [DATA_W:0]     r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic [DATA_W-1:0]   r_rd_data;
    logic                w_push;
    logic                w_pop;
    logic [DATA_W:0]     w_entry;

    assign full        = (r_count == c_depth);
    assign empty       = (r_count == '0);
    assign w_push      = wr_en & ~full;
    assign w_pop       = rd_en & ~empty;
    assign w_entry     = {wr_marker, (wr_marker ? {DATA_W{1'b0}} : wr_data)};
    assign head_marker = r_mem[r_rd_ptr][DATA_W];
    assign rd_data     = r_rd_data;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + c_addr_w'(1);
                r_rd_data <= r_mem[r_rd_ptr][DATA_W-1:0];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_addr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_addr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/stub_event_player.sv
`default_nettype none
// ============================================================================
// Module   : stub_event_player
// Brief    : Replays one event per EVT_CLKS-cycle window, BC0 aligned.
//            Define STUB_PLAYER_STATS_EN to build trunc/realign counters.
// Revision : 1.0 - initial release
// ============================================================================
module stub_event_player
    import stub_player_pkg::*;
#(
    parameter int STUB_W   = c_stub_w,
    parameter int EVT_CLKS = 6,
    parameter int DEPTH    = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   BC0,
    input  logic                   wr_en,
    input  logic [STUB_W-1:0]      wr_data,
    input  logic                   wr_marker,
    output logic                   full,
    output logic                   overflow,
    output logic [STUB_W-1:0]      data_out,
    output logic                   valid,
    output logic                   start,
    output logic [c_trunc_w-1:0]   trunc_cnt,
    output logic [c_realign_w-1:0] realign_cnt
);

    localparam int c_idx_w = $clog2(EVT_CLKS);
    localparam logic [c_idx_w-1:0] c_idx_last     = c_idx_w'(EVT_CLKS - 1);
    localparam logic [c_idx_w-1:0] c_idx_last_pop = c_idx_w'(EVT_CLKS - 2);

    player_state_t      r_state;
    player_state_t      w_cur_state;
    player_state_t      w_next_state;
    logic [c_idx_w-1:0] r_idx;
    logic [c_idx_w-1:0] w_idx;
    logic [c_idx_w-1:0] w_idx_next;
    logic               r_valid;
    logic               r_overflow;
    logic               w_pop;
    logic               w_out;
    logic               w_wr_any;
    logic               w_empty;
    logic               w_head_marker;

    assign w_wr_any = wr_en | wr_marker;

    stub_fifo #(
        .DATA_W (STUB_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (w_wr_any),
        .wr_marker   (wr_marker),
        .wr_data     (wr_data),
        .rd_en       (w_pop),
        .rd_data     (data_out),
        .head_marker (w_head_marker),
        .full        (full),
        .empty       (w_empty)
    );

    // BC0 makes the current cycle index 0 and acts as a window boundary.
    always_comb begin
        w_idx       = BC0 ? '0 : r_idx;
        w_cur_state = r_state;
        case (r_state)
            IDLE:    if (BC0)           w_cur_state = RUN;
            RUN:     if (w_idx == '0)   w_cur_state = DROP;
            WAIT:    if (w_idx == '0)   w_cur_state = RUN;
            default:                    w_cur_state = DROP;
        endcase

        w_pop = ~w_empty &
                (((w_cur_state == RUN) && (w_idx <= c_idx_last_pop)) ||
                 (w_cur_state == DROP));
        w_out = w_pop & ~w_head_marker & (w_cur_state == RUN);

        // A marker dropped in the last slot has no slot left to run in.
        w_next_state = w_cur_state;
        if (w_pop && w_head_marker) begin
            if (w_cur_state == RUN || w_idx == c_idx_last) begin
                w_next_state = WAIT;
            end else begin
                w_next_state = RUN;
            end
        end

        if (w_cur_state == IDLE || w_idx == c_idx_last) begin
            w_idx_next = '0;
        end else begin
            w_idx_next = w_idx + c_idx_w'(1);
        end
    end

    assign start    = (w_cur_state != IDLE) && (w_idx == '0);
    assign valid    = r_valid;
    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_idx_next;
            r_valid <= w_out;
            if (w_wr_any && full) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef STUB_PLAYER_STATS_EN
    logic [c_trunc_w-1:0]   r_trunc_cnt;
    logic [c_realign_w-1:0] r_realign_cnt;
    logic                   w_trunc_inc;
    logic                   w_realign_inc;

    assign w_trunc_inc   = w_pop & ~w_head_marker & (w_cur_state == DROP);
    assign w_realign_inc = BC0 & (r_state != IDLE) & (r_idx != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_trunc_cnt   <= '0;
            r_realign_cnt <= '0;
        end else begin
            if (w_trunc_inc && (r_trunc_cnt != '1)) begin
                r_trunc_cnt <= r_trunc_cnt + c_trunc_w'(1);
            end
            if (w_realign_inc && (r_realign_cnt != '1)) begin
                r_realign_cnt <= r_realign_cnt + c_realign_w'(1);
            end
        end
    end

    assign trunc_cnt   = r_trunc_cnt;
    assign realign_cnt = r_realign_cnt;
`else
    assign trunc_cnt   = '0;
    assign realign_cnt = '0;
`endif

endmodule
`default_nettype wire
